// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: hazard-controller state encoding and
// register-select field positions within a 32-bit instruction word.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK) begin
    if (RST)
      count <= '0;
    else if (inc && !(&count))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch enable/flush generation: memory-wait freeze, redirect flush,
// load-use bubble, halt tracking and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [31:0]      id_instr,
  input  logic             ex_dREN,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic             ex_redirect,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_halt,
  output logic             pcEN,
  output logic             ifid_EN,
  output logic             ifid_flush,
  output logic             idex_EN,
  output logic             idex_flush,
  output logic             exmem_EN,
  output logic             exmem_flush,
  output logic             memwb_EN,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state, state_n;

  logic             memop, advance, load_use;
  logic             stall_inc, flush_inc;
  logic [REG_W-1:0] rs_sel, rt_sel;
  logic             unused_instr_bits;

  assign unused_instr_bits = ^{id_instr[31:RS_MSB+1], id_instr[RT_LSB-1:0]};

  assign rs_sel   = REG_W'(id_instr[RS_MSB:RS_LSB]);
  assign rt_sel   = REG_W'(id_instr[RT_MSB:RT_LSB]);
  assign memop    = mem_dREN | mem_dWEN;
  assign advance  = ihit & (~memop | dhit);
  // rt is always compared, even for instructions that never read it
  assign load_use = ex_dREN && (ex_wsel != '0) &&
                    ((ex_wsel == rs_sel) || (ex_wsel == rt_sel));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      state <= state_n;
      halt  <= (state_n == HALTED);
    end
  end

  always_comb begin
    state_n     = state;
    pcEN        = 1'b0;
    ifid_EN     = 1'b0;
    ifid_flush  = 1'b0;
    idex_EN     = 1'b0;
    idex_flush  = 1'b0;
    exmem_EN    = 1'b0;
    exmem_flush = 1'b0;
    memwb_EN    = 1'b0;
    if (RST) begin
      state_n     = RUN;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (state != HALTED) begin
      if (!advance) begin
        // freeze; redirects wait because EX holds its contents
        if (memop && !dhit)
          state_n = DWAIT;
      end else begin
        state_n     = mem_halt ? HALTED : RUN;
        exmem_flush = mem_halt;
        exmem_EN    = 1'b1;
        memwb_EN    = 1'b1;
        idex_EN     = 1'b1;
        if (ex_redirect) begin
          pcEN       = 1'b1;
          ifid_EN    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          idex_flush = 1'b1;
        end else begin
          pcEN    = 1'b1;
          ifid_EN = 1'b1;
        end
      end
    end
  end

  assign stall_inc = !RST && !pcEN && (state != HALTED);
  assign flush_inc = !RST && (state != HALTED) && advance && ex_redirect;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations,
// then random traffic checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit, dhit, ex_dREN, ex_redirect, mem_dREN, mem_dWEN, mem_halt;
  logic [31:0] id_instr;
  logic [4:0]  ex_wsel;

  logic        pcEN, ifid_EN, ifid_flush, idex_EN, idex_flush;
  logic        exmem_EN, exmem_flush, memwb_EN, halt;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pcEN, s_ifid_EN, s_ifid_flush, s_idex_EN, s_idex_flush;
  logic        s_exmem_EN, s_exmem_flush, s_memwb_EN, s_halt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .id_instr(id_instr),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_redirect(ex_redirect),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .pcEN(pcEN), .ifid_EN(ifid_EN), .ifid_flush(ifid_flush),
    .idex_EN(idex_EN), .idex_flush(idex_flush), .exmem_EN(exmem_EN),
    .exmem_flush(exmem_flush), .memwb_EN(memwb_EN), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(2)) dut_s (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .id_instr(id_instr),
    .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .ex_redirect(ex_redirect),
    .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
    .pcEN(s_pcEN), .ifid_EN(s_ifid_EN), .ifid_flush(s_ifid_flush),
    .idex_EN(s_idex_EN), .idex_flush(s_idex_flush), .exmem_EN(s_exmem_EN),
    .exmem_flush(s_exmem_flush), .memwb_EN(s_memwb_EN), .halt(s_halt),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // Control vector order: pcEN ifid_EN ifid_flush idex_EN idex_flush exmem_EN exmem_flush memwb_EN
  logic [7:0] ctl, s_ctl;
  assign ctl   = {pcEN, ifid_EN, ifid_flush, idex_EN, idex_flush, exmem_EN, exmem_flush, memwb_EN};
  assign s_ctl = {s_pcEN, s_ifid_EN, s_ifid_flush, s_idex_EN, s_idex_flush,
                  s_exmem_EN, s_exmem_flush, s_memwb_EN};

  // ---------------- behavioural model ----------------
  bit m_halted = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  function automatic logic [7:0] model_ctl();
    bit adv, lu;
    if (RST) return 8'b0010_1010;
    if (m_halted) return 8'h00;
    adv = ihit && (!(mem_dREN || mem_dWEN) || dhit);
    if (!adv) return 8'h00;
    lu = ex_dREN && ex_wsel != 0 &&
         (ex_wsel == id_instr[25:21] || ex_wsel == id_instr[20:16]);
    if (ex_redirect)
      return {6'b111111, mem_halt, 1'b1};
    else if (lu)
      return {6'b000111, mem_halt, 1'b1};
    else
      return {6'b110101, mem_halt, 1'b1};
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge CLK) begin
    logic [7:0] e;
    bit adv;
    e   = model_ctl();
    adv = ihit && (!(mem_dREN || mem_dWEN) || dhit);
    if (RST) begin
      m_halted = 1'b0;
      m_stall  = 0;
      m_flush  = 0;
    end else if (!m_halted) begin
      if (!e[7]) m_stall++;
      if (adv && ex_redirect) m_flush++;
      if (adv && mem_halt) m_halted = 1'b1;
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("ctl",         ctl,         model_ctl());
      chk("s_ctl",       s_ctl,       model_ctl());
      chk("halt",        halt,        m_halted);
      chk("stall_cnt",   stall_cnt,   sat(m_stall, 65535));
      chk("flush_cnt",   flush_cnt,   sat(m_flush, 65535));
      chk("s_stall_cnt", s_stall_cnt, sat(m_stall, 3));
      chk("s_flush_cnt", s_flush_cnt, sat(m_flush, 3));
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_in();
    ihit = 1'b1; dhit = 1'b0; ex_dREN = 1'b0; ex_wsel = '0; id_instr = '0;
    ex_redirect = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0; mem_halt = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_in();
    step();
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    clear_in();
    ihit = 1'b0;
    @(negedge CLK);
    chk("reset_ctl", ctl, 8'h2A);
    step();
    chk_en = 1'b1;
    RST = 1'b0;
    clear_in();
    @(negedge CLK);
    chk("post_reset_halt", halt, 0);
    chk("post_reset_ctl", ctl, 8'hD5);
    repeat (10) step();
    @(negedge CLK);
    chk("clean_stall", stall_cnt, 0);
    chk("clean_flush", flush_cnt, 0);

    // load-use on rs
    step();
    ex_dREN = 1'b1; ex_wsel = 5'd5; id_instr = 32'h00A53020;
    @(negedge CLK);
    chk("lu_ctl", ctl, 8'h1D);
    step();
    clear_in();
    @(negedge CLK);
    chk("lu_stall", stall_cnt, 1);
    ex_dREN = 1'b1; ex_wsel = 5'd0; id_instr = 32'h00003020;
    @(negedge CLK);
    chk("lu_r0_ctl", ctl, 8'hD5);
    step();
    @(negedge CLK);
    chk("lu_r0_stall", stall_cnt, 1);

    // data wait: 3 frozen cycles then advance
    do_reset();
    mem_dREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("dwait_ctl", ctl, 8'h00);
      step();
    end
    dhit = 1'b1;
    @(negedge CLK);
    chk("dwait_adv_ctl", ctl, 8'hD5);
    step();
    clear_in();
    @(negedge CLK);
    chk("dwait_stall", stall_cnt, 3);

    // redirect beats load-use
    do_reset();
    ex_redirect = 1'b1; ex_dREN = 1'b1; ex_wsel = 5'd5; id_instr = 32'h00A53020;
    @(negedge CLK);
    chk("redir_lu_ctl", ctl, 8'hFD);
    step();
    clear_in();
    @(negedge CLK);
    chk("redir_flush", flush_cnt, 1);
    chk("redir_stall", stall_cnt, 0);

    // saturation on the 2-bit instance
    do_reset();
    ihit = 1'b0;
    repeat (5) step();
    clear_in();
    @(negedge CLK);
    chk("sat_stall_s", s_stall_cnt, 3);
    chk("sat_stall", stall_cnt, 5);
    step();
    @(negedge CLK);
    chk("sat_hold_s", s_stall_cnt, 3);

    // halt
    do_reset();
    mem_halt = 1'b1;
    @(negedge CLK);
    chk("halt_edge_ctl", ctl, 8'hD7);
    chk("halt_edge_halt", halt, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      ihit = 1'($urandom); dhit = 1'($urandom); ex_redirect = 1'($urandom);
      mem_dREN = 1'($urandom); mem_halt = 1'($urandom);
      @(negedge CLK);
      chk("halted_ctl", ctl, 8'h00);
      chk("halted_halt", halt, 1);
      step();
    end
    do_reset();
    @(negedge CLK);
    chk("halt_exit", halt, 0);
    chk("halt_exit_ctl", ctl, 8'hD5);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      RST         = ($urandom_range(0, 99) == 0);
      ihit        = ($urandom_range(0, 3) != 0);
      dhit        = ($urandom_range(0, 2) != 0);
      ex_dREN     = 1'($urandom);
      ex_wsel     = 5'($urandom_range(0, 3));
      id_instr    = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     16'($urandom)};
      ex_redirect = ($urandom_range(0, 4) == 0);
      mem_dREN    = ($urandom_range(0, 3) == 0);
      mem_dWEN    = ($urandom_range(0, 5) == 0);
      mem_halt    = ($urandom_range(0, 49) == 0);
    end
    step();
    @(negedge CLK);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
